apb3_txn_scheduler: RTL

//  Sequences AXI4-Lite-side read and write requests onto a single APB3 master port.

---
 rtl/apb3_txn_scheduler_pkg.sv | 25 ++
 rtl/apb3_txn_scheduler_if.sv | 48 ++++
 rtl/apb3_txn_scheduler_rr_arbiter2.sv | 37 +++
 rtl/apb3_txn_scheduler.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/apb3_txn_scheduler_pkg.sv
// apb_bridge_pkg: FSM, grant and response encodings shared by apb3_txn_scheduler
// and its round-robin arbiter.
package apb_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ACCESS = 3'd2,
      WRESP  = 3'd3,
      RRESP  = 3'd4
   } state_t;

   typedef enum logic {
      GNT_WRITE = 1'b0,
      GNT_READ  = 1'b1
   } grant_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic [1:0] apb_resp(input logic i_slverr);
      return i_slverr ? RESP_SLVERR : RESP_OKAY;
   endfunction

endpackage

// File: rtl/apb3_txn_scheduler_if.sv
// Request/response queues plus APB3 master signals of apb3_txn_scheduler.
// master = scheduler side, slave = front end / APB slave side.
interface apb3_txn_scheduler_if #(
   parameter int ADDRESS    = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  wr_req_valid;
   logic                  wr_req_ready;
   logic [ADDRESS-1:0]    wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [3:0]            wr_strb;
   logic                  wr_rsp_valid;
   logic                  wr_rsp_ready;
   logic [1:0]            wr_rsp_resp;
   logic                  rd_req_valid;
   logic                  rd_req_ready;
   logic [ADDRESS-1:0]    rd_addr;
   logic                  rd_rsp_valid;
   logic                  rd_rsp_ready;
   logic [DATA_WIDTH-1:0] rd_rsp_data;
   logic [1:0]            rd_rsp_resp;
   logic [ADDRESS-1:0]    PADDR;
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic                  PREADY;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PSLVERR;

   modport master (
      input  wr_req_valid, wr_addr, wr_data, wr_strb, wr_rsp_ready,
      input  rd_req_valid, rd_addr, rd_rsp_ready,
      input  PREADY, PRDATA, PSLVERR,
      output wr_req_ready, wr_rsp_valid, wr_rsp_resp,
      output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_resp,
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA
   );

   modport slave (
      output wr_req_valid, wr_addr, wr_data, wr_strb, wr_rsp_ready,
      output rd_req_valid, rd_addr, rd_rsp_ready,
      output PREADY, PRDATA, PSLVERR,
      input  wr_req_ready, wr_rsp_valid, wr_rsp_resp,
      input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_resp,
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
   );
endinterface

// File: rtl/apb3_txn_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin (write vs read). Combinational grant,
// last_grant register advances only when the granted request is accepted.
module rr_arbiter2
   import apb_bridge_pkg::*;
(
   input  logic   i_clk,
   input  logic   i_rst,
   input  logic   i_req_w,
   input  logic   i_req_r,
   input  logic   i_accept,
   output grant_t o_gnt,
   output logic   o_gnt_valid
);
   grant_t r_last;

   always_comb begin
      o_gnt = GNT_WRITE;
      if (i_req_w && i_req_r) begin
         o_gnt = (r_last == GNT_READ) ? GNT_WRITE : GNT_READ;
      end else if (i_req_r) begin
         o_gnt = GNT_READ;
      end else begin
         o_gnt = GNT_WRITE;
      end
   end

   assign o_gnt_valid = i_req_w | i_req_r;

   // READ after reset so the first tie goes to the write side
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_last <= GNT_READ;
      end else if (i_accept) begin
         r_last <= o_gnt;
      end
   end
endmodule

// File: rtl/apb3_txn_scheduler.sv
// apb3_txn_scheduler: one-at-a-time AXI4-Lite request sequencer onto an APB3 master.
// Optional ACCESS watchdog enabled by defining APB_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module apb3_txn_scheduler
   import apb_bridge_pkg::*;
#(
   parameter int ADDRESS    = 32,
   parameter int DATA_WIDTH = 32
`ifdef APB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 256
`endif
)(
   input  logic                 ACLK,
   input  logic                 ARESET,
   apb3_txn_scheduler_if.master bus
);
   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDRESS-1:0]    r_paddr;
   logic                  r_pwrite;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic [1:0]            r_wr_resp;
   logic [1:0]            r_rd_resp;
   logic [DATA_WIDTH-1:0] r_rd_data;
   grant_t                w_gnt;
   logic                  w_gnt_valid;
   logic                  w_idle;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_full_strb;
   logic                  w_tmo;

   rr_arbiter2 u_arb (
      .i_clk       (ACLK),
      .i_rst       (ARESET),
      .i_req_w     (bus.wr_req_valid),
      .i_req_r     (bus.rd_req_valid),
      .i_accept    (w_wr_acc | w_rd_acc),
      .o_gnt       (w_gnt),
      .o_gnt_valid (w_gnt_valid)
   );

   assign w_idle           = (r_state == IDLE);
   assign bus.wr_req_ready = w_idle && w_gnt_valid && (w_gnt == GNT_WRITE);
   assign bus.rd_req_ready = w_idle && w_gnt_valid && (w_gnt == GNT_READ);
   assign w_wr_acc         = bus.wr_req_valid && bus.wr_req_ready;
   assign w_rd_acc         = bus.rd_req_valid && bus.rd_req_ready;
   // APB3 has no PSTRB, so only full-word writes reach the bus
   assign w_full_strb      = (bus.wr_strb == 4'hF);

`ifdef APB_TIMEOUT_EN
   localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0] r_tmo_cnt;

   assign w_tmo = (r_state == ACCESS) && !bus.PREADY && (r_tmo_cnt == TMO_LAST);

   // Counts stalled ACCESS cycles; held at zero outside ACCESS
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_tmo_cnt <= {TMO_W{1'b0}};
      end else if (r_state != ACCESS) begin
         r_tmo_cnt <= {TMO_W{1'b0}};
      end else if (!bus.PREADY) begin
         r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
   end
`else
   assign w_tmo = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_wr_acc) begin
               w_state_nxt = w_full_strb ? SETUP : WRESP;
            end else if (w_rd_acc) begin
               w_state_nxt = SETUP;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SETUP:  w_state_nxt = ACCESS;
         ACCESS: begin
            if (bus.PREADY || w_tmo) begin
               w_state_nxt = r_pwrite ? WRESP : RRESP;
            end else begin
               w_state_nxt = ACCESS;
            end
         end
         WRESP:  w_state_nxt = bus.wr_rsp_ready ? IDLE : WRESP;
         RRESP:  w_state_nxt = bus.rd_rsp_ready ? IDLE : RRESP;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // APB address phase is latched once per grant; responses captured at the end of ACCESS
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_paddr   <= {ADDRESS{1'b0}};
         r_pwrite  <= 1'b0;
         r_pwdata  <= {DATA_WIDTH{1'b0}};
         r_wr_resp <= RESP_OKAY;
         r_rd_resp <= RESP_OKAY;
         r_rd_data <= {DATA_WIDTH{1'b0}};
      end else if (w_wr_acc && w_full_strb) begin
         r_paddr  <= bus.wr_addr;
         r_pwrite <= 1'b1;
         r_pwdata <= bus.wr_data;
      end else if (w_wr_acc) begin
         r_wr_resp <= RESP_SLVERR;
      end else if (w_rd_acc) begin
         r_paddr  <= bus.rd_addr;
         r_pwrite <= 1'b0;
         r_pwdata <= {DATA_WIDTH{1'b0}};
      end else if ((r_state == ACCESS) && w_tmo) begin
         if (r_pwrite) begin
            r_wr_resp <= RESP_SLVERR;
         end else begin
            r_rd_resp <= RESP_SLVERR;
            r_rd_data <= {DATA_WIDTH{1'b0}};
         end
      end else if ((r_state == ACCESS) && bus.PREADY) begin
         if (r_pwrite) begin
            r_wr_resp <= apb_resp(bus.PSLVERR);
         end else begin
            r_rd_resp <= apb_resp(bus.PSLVERR);
            r_rd_data <= bus.PRDATA;
         end
      end
   end

   assign bus.PSEL         = (r_state == SETUP) || (r_state == ACCESS);
   assign bus.PENABLE      = (r_state == ACCESS);
   assign bus.PADDR        = r_paddr;
   assign bus.PWRITE       = r_pwrite;
   assign bus.PWDATA       = r_pwdata;
   assign bus.wr_rsp_valid = (r_state == WRESP);
   assign bus.wr_rsp_resp  = r_wr_resp;
   assign bus.rd_rsp_valid = (r_state == RRESP);
   assign bus.rd_rsp_resp  = r_rd_resp;
   assign bus.rd_rsp_data  = r_rd_data;
endmodule
